// File: rtl/sprite_pkg.sv
// Shared screen geometry, coordinate/palette types and small helpers for the sprite renderer.
package sprite_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PAL_IDX_W = 3;

  typedef logic [9:0]           coord_t;
  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  // Counter width that stays legal when the count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Span test done at 11 bits so lo+len past the screen edge clips instead of wrapping.
  function automatic logic in_span(input coord_t v, input coord_t lo, input int unsigned len);
    logic [10:0] hi;
    hi = {1'b0, lo} + 11'(len);
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < hi);
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation counter: FRAME_TICKS frame_start pulses per animation frame, N_FRAMES frames then wrap.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 6,
  parameter int FRM_W       = cnt_w(N_FRAMES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             anim_en,
  output logic [FRM_W-1:0] frame_idx
);

  localparam int TICK_W = cnt_w(FRAME_TICKS);

  logic [TICK_W-1:0] tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick      <= '0;
      frame_idx <= '0;
    end else if (frame_start && anim_en) begin
      if (tick == TICK_W'(FRAME_TICKS - 1)) begin
        tick      <= '0;
        frame_idx <= (frame_idx == FRM_W'(N_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Two-stage animated sprite renderer: box test + ROM address, then palette index / opacity.
// Optional horizontal mirroring is built when SPRITE_FLIP_EN is defined.
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 64,
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 6,
  parameter int IDX_W       = 3,
  parameter int TRANSP_IDX  = 0,
  parameter int ADDR_W      = $clog2(SPR_W*SPR_H*N_FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
`ifdef SPRITE_FLIP_EN
  input  logic              flip,
`endif
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit
);

  localparam int FRM_W = cnt_w(N_FRAMES);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_PIX   = ADDR_W'(SPR_W);

  coord_t            px, py;
  logic              flp;
  logic [FRM_W-1:0]  frame_idx;
  coord_t            dx, lx, ly;
  logic              in_box;
  logic [ADDR_W-1:0] addr_calc;
  logic              in_box_d1, blank_d1;

  sprite_anim_ctr #(
    .N_FRAMES    (N_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FRM_W       (FRM_W)
  ) u_ctr (
    .clk         (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .frame_idx   (frame_idx)
  );

  // Position and mirroring only change at frame boundaries so a sprite never tears mid-frame.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (frame_start) begin
      px <= pos_x;
      py <= pos_y;
    end
  end

`ifdef SPRITE_FLIP_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      flp <= 1'b0;
    end else if (frame_start) begin
      flp <= flip;
    end
  end
`else
  assign flp = 1'b0;
`endif

  always_comb begin
    in_box    = in_span(DrawX, px, SPR_W) && in_span(DrawY, py, SPR_H);
    dx        = DrawX - px;
    lx        = flp ? (coord_t'(SPR_W - 1) - dx) : dx;
    ly        = DrawY - py;
    addr_calc = ADDR_W'(frame_idx) * FRAME_PIX + ADDR_W'(ly) * ROW_PIX + ADDR_W'(lx);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      in_box_d1   <= 1'b0;
      blank_d1    <= 1'b0;
    end else begin
      rom_address <= in_box ? addr_calc : '0;
      in_box_d1   <= in_box;
      blank_d1    <= blank;
    end
  end

  // rom_q answers the address registered last cycle, so it lines up with the _d1 flags.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_idx <= '0;
      pix_hit <= 1'b0;
    end else begin
      pix_idx <= rom_q;
      pix_hit <= in_box_d1 && blank_d1 && (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer with a combinational ROM model behind rom_address.
module tb_sprite_anim_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, frame_start, anim_en;
  logic        flip;
  logic [13:0] rom_address;
  logic [2:0]  rom_q, pix_idx;
  logic        pix_hit;
  logic        force_transp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_anim_renderer dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
`ifdef SPRITE_FLIP_EN
    .flip        (flip),
`endif
    .anim_en     (anim_en),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_idx     (pix_idx),
    .pix_hit     (pix_hit)
  );

  // Never returns the transparent index, so every in-box pixel is opaque unless forced.
  function automatic logic [2:0] rom_fn(input logic [13:0] a);
    return 3'((int'(a) % 7) + 1);
  endfunction

  always_comb rom_q = force_transp ? 3'd0 : rom_fn(rom_address);

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(1);
    end
  endtask

  // Present a pixel, then check the address after one edge and hit/index after two.
  task automatic probe(input string tag, input int x, input int y,
                       input int exp_addr, input int exp_hit);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step(1);
    chk({tag, "_addr"}, int'(rom_address), exp_addr);
    step(1);
    chk({tag, "_hit"}, int'(pix_hit), exp_hit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; flip = 1'b0; anim_en = 1'b0; force_transp = 1'b0;
    #12;
    chk("rst_addr", int'(rom_address), 0);
    chk("rst_idx",  int'(pix_idx), 0);
    chk("rst_hit",  int'(pix_hit), 0);
    step(1);
    reset = 1'b0;

    pos_x = 10'd100; pos_y = 10'd50;
    pulse(1);
    probe("origin", 100, 50, 0, 1);
    chk("origin_idx", int'(pix_idx), int'(rom_fn(14'd0)));
    probe("corner", 149, 113, 3199, 1);
    chk("corner_idx", int'(pix_idx), int'(rom_fn(14'd3199)));
    probe("right_out", 150, 113, 0, 0);
    probe("below_out", 100, 114, 0, 0);
    probe("left_out", 99, 50, 0, 0);

    pos_x = 10'd200;
    probe("midframe_old", 100, 50, 0, 1);
    probe("midframe_new", 210, 50, 0, 0);
    pos_x = 10'd100;

    anim_en = 1'b1;
    pulse(5);
    probe("tick5", 100, 50, 0, 1);
    pulse(1);
    probe("frame1", 100, 50, 3200, 1);
    probe("frame1_corner", 149, 113, 6399, 1);
    pulse(6);
    probe("frame2", 100, 50, 6400, 1);
    pulse(12);
    probe("frame_wrap", 100, 50, 0, 1);

    force_transp = 1'b1;
    probe("transp", 101, 50, 1, 0);
    chk("transp_idx", int'(pix_idx), 0);
    force_transp = 1'b0;
    blank = 1'b0;
    probe("blanked", 101, 50, 1, 0);
    blank = 1'b1;

    anim_en = 1'b0;
    pos_x = 10'd620;
    pulse(1);
    probe("clip_edge", 639, 50, 19, 1);
    probe("clip_x0", 0, 50, 0, 0);
    probe("clip_nowrap", 5, 50, 0, 0);

`ifdef SPRITE_FLIP_EN
    pos_x = 10'd100; flip = 1'b1;
    pulse(1);
    probe("flip_left", 100, 50, 49, 1);
    probe("flip_right", 149, 50, 0, 1);
    pos_x = 10'd200; flip = 1'b0;
    probe("flip_hold", 100, 50, 49, 1);
    pos_x = 10'd100;
    pulse(1);
    probe("flip_off", 100, 50, 0, 1);
`endif

    pos_x = 10'd100; anim_en = 1'b1;
    pulse(12);
    probe("pre_rst_f2", 100, 50, 6400, 1);
    DrawX = 10'd101; DrawY = 10'd51;
    step(1);
    reset = 1'b1; frame_start = 1'b1;
    #1;
    chk("rst_fs_addr", int'(rom_address), 0);
    chk("rst_fs_hit",  int'(pix_hit), 0);
    step(1);
    reset = 1'b0; frame_start = 1'b0;
    DrawX = 10'd5; DrawY = 10'd5;
    step(1);
    chk("post_rst_hit", int'(pix_hit), 0);
    chk("post_rst_idx", int'(pix_idx), int'(rom_fn(14'd0)));
    pulse(1);
    probe("post_rst_f0", 101, 51, 51, 1);
    pulse(4);
    probe("post_rst_t5", 101, 51, 51, 1);
    pulse(1);
    probe("post_rst_f1", 101, 51, 3251, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
